// File: rtl/decode_unescape_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_unescape_fetch_if
// Description : Bundles the byte-stream input and the assembled-instruction
//               output of the decoder front end.
//   Byte side  : byte_valid, byte_in[7:0], byte_last  -> block
//                byte_ready                           <- block
//   Instr side : out_valid, unescaped_instr[71:0], is_2byte, body_len[3:0],
//                pfx_opsize, pfx_addrsize, pfx_lock, pfx_rep, pfx_repne,
//                pfx_seg[2:0], instr_err              <- block
//                out_ready                            -> block
//   master     : the front-end block (instruction producer)
//   slave      : the surroundings (byte source and phase-2 consumer)
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_unescape_fetch_if;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic        byte_last;
  logic        byte_ready;

  logic        out_valid;
  logic        out_ready;
  logic [71:0] unescaped_instr;
  logic        is_2byte;
  logic [3:0]  body_len;
  logic        pfx_opsize;
  logic        pfx_addrsize;
  logic        pfx_lock;
  logic        pfx_rep;
  logic        pfx_repne;
  logic [2:0]  pfx_seg;
  logic        instr_err;

  modport master (
    input  byte_valid, byte_in, byte_last, out_ready,
    output byte_ready, out_valid, unescaped_instr, is_2byte, body_len,
           pfx_opsize, pfx_addrsize, pfx_lock, pfx_rep, pfx_repne,
           pfx_seg, instr_err
  );

  modport slave (
    output byte_valid, byte_in, byte_last, out_ready,
    input  byte_ready, out_valid, unescaped_instr, is_2byte, body_len,
           pfx_opsize, pfx_addrsize, pfx_lock, pfx_rep, pfx_repne,
           pfx_seg, instr_err
  );
endinterface
`default_nettype wire

// File: rtl/decode_unescape_fetch.sv
`default_nettype none
// ============================================================================
// Module      : decode_unescape_fetch
// Description : Byte-serial x86 decoder front end. Takes one raw byte per
//               cycle, strips legacy prefixes and the 0x0F escape, and packs
//               up to 9 body bytes into a 72-bit word handed to decode
//               phase 2 over a valid/ready handshake.
//   clk   : sole clock, rising edge
//   rst   : synchronous, active-high reset
//   bus   : decode_unescape_fetch_if.master (byte stream in, instruction out)
// Revision    : 1.0 - initial release
// ============================================================================
module decode_unescape_fetch (
  input  wire                           clk,
  input  wire                           rst,
  decode_unescape_fetch_if.master       bus
);

  typedef enum logic [1:0] {
    S_PREFIX = 2'd0,
    S_BODY   = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] BODY_MAX  = 4'd9;
  localparam logic [3:0] TOTAL_MAX = 4'd15;

  state_t      state;
  logic        ready;
  logic        valid;
  logic [71:0] instr;
  logic        two_byte;
  logic [3:0]  len;
  logic [3:0]  total;
  logic        opsize;
  logic        addrsize;
  logic        lock;
  logic        rep;
  logic        repne;
  logic [2:0]  seg;
  logic        err;

  logic        accept;
  logic [7:0]  b;
  logic        is_seg;
  logic [2:0]  seg_code;
  logic        is_pfx;

  // ready mirrors (state != S_HOLD) but is kept as its own flop so that
  // byte_ready leaves the block straight from a register.
  assign accept = bus.byte_valid & ready;
  assign b      = bus.byte_in;

  // Segment override decode; code 0 is reserved for "no override".
  always_comb begin
    is_seg   = 1'b1;
    seg_code = 3'd0;
    case (b)
      8'h26:   seg_code = 3'd1;
      8'h2E:   seg_code = 3'd2;
      8'h36:   seg_code = 3'd3;
      8'h3E:   seg_code = 3'd4;
      8'h64:   seg_code = 3'd5;
      8'h65:   seg_code = 3'd6;
      default: is_seg   = 1'b0;
    endcase
  end

  always_comb begin
    is_pfx = is_seg;
    case (b)
      8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3: is_pfx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_PREFIX;
      ready    <= 1'b1;
      valid    <= 1'b0;
      instr    <= 72'd0;
      two_byte <= 1'b0;
      len      <= 4'd0;
      total    <= 4'd0;
      opsize   <= 1'b0;
      addrsize <= 1'b0;
      lock     <= 1'b0;
      rep      <= 1'b0;
      repne    <= 1'b0;
      seg      <= 3'd0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_PREFIX, S_BODY: begin
          if (accept) begin
            if (total != TOTAL_MAX) begin
              total <= total + 4'd1;
            end

            if (total == TOTAL_MAX) begin
              // 16th (or later) byte of one instruction: dropped.
              err <= 1'b1;
            end else if (state == S_PREFIX) begin
              if (is_pfx) begin
                if (is_seg)    seg      <= seg_code;
                if (b == 8'h66) opsize   <= 1'b1;
                if (b == 8'h67) addrsize <= 1'b1;
                if (b == 8'hF0) lock     <= 1'b1;
                if (b == 8'hF3) rep      <= 1'b1;
                if (b == 8'hF2) repne    <= 1'b1;
                // Instruction ended with no opcode at all.
                if (bus.byte_last) err <= 1'b1;
              end else if (b == 8'h0F) begin
                two_byte <= 1'b1;
                state    <= S_BODY;
                // Escape with nothing after it.
                if (bus.byte_last) err <= 1'b1;
              end else begin
                instr[7:0] <= b;
                len        <= 4'd1;
                state      <= S_BODY;
              end
            end else begin
              // In the body every byte is data, including 0x0F.
              if (len == BODY_MAX) begin
                err <= 1'b1;
              end else begin
                instr[{len, 3'b000} +: 8] <= b;
                len <= len + 4'd1;
              end
            end

            // Overrides any S_BODY move made above.
            if (bus.byte_last) begin
              state <= S_HOLD;
              ready <= 1'b0;
              valid <= 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (bus.out_ready) begin
            state    <= S_PREFIX;
            ready    <= 1'b1;
            valid    <= 1'b0;
            instr    <= 72'd0;
            two_byte <= 1'b0;
            len      <= 4'd0;
            total    <= 4'd0;
            opsize   <= 1'b0;
            addrsize <= 1'b0;
            lock     <= 1'b0;
            rep      <= 1'b0;
            repne    <= 1'b0;
            seg      <= 3'd0;
            err      <= 1'b0;
          end
        end

        default: begin
          state <= S_PREFIX;
          ready <= 1'b1;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready      = ready;
  assign bus.out_valid       = valid;
  assign bus.unescaped_instr = instr;
  assign bus.is_2byte        = two_byte;
  assign bus.body_len        = len;
  assign bus.pfx_opsize      = opsize;
  assign bus.pfx_addrsize    = addrsize;
  assign bus.pfx_lock        = lock;
  assign bus.pfx_rep         = rep;
  assign bus.pfx_repne       = repne;
  assign bus.pfx_seg         = seg;
  assign bus.instr_err       = err;

endmodule
`default_nettype wire
